cbus_ram_responder: RTL and testbench

//  Bus-side responder in front of a byte-strobed single-port RAM. Accepts cbus

---
 rtl/cbus_ram_responder_pkg.sv | 35 +++
 rtl/cbus_ram_responder_if.sv | 26 ++
 rtl/cbus_burst_addr_gen.sv | 61 ++++++
 rtl/cbus_ram_responder.sv | 115 +++++++++++
 tb/tb_cbus_ram_responder.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbus_ram_responder_pkg.sv
// Shared types and constants for the cbus RAM responder and its burst address generator.
package cbus_ram_responder_pkg;

  localparam int unsigned LEN_W     = 4;
  localparam int unsigned REQ_ADDR_W = 64;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  typedef struct packed {
    logic              is_write;
    logic [LEN_W-1:0]  len;
    burst_t            burst;
  } req_ctl_t;

  typedef struct packed {
    logic ready;
    logic last;
  } resp_tok_t;

  function automatic int unsigned byte_ofs(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/cbus_ram_responder_if.sv
// cbus request/response bundle between the initiator (master) and the RAM responder (slave).
interface cbus_ram_responder_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_LEN    = 16
);
  logic                          req_valid;
  logic                          req_is_write;
  logic [63:0]                   req_addr;
  logic [$clog2(MAX_LEN)-1:0]    req_len;
  logic [1:0]                    req_burst;
  logic [DATA_WIDTH/8-1:0]       req_strobe;
  logic [DATA_WIDTH-1:0]         req_data;
  logic                          resp_ready;
  logic                          resp_last;
  logic [DATA_WIDTH-1:0]         resp_data;

  modport master (
    output req_valid, req_is_write, req_addr, req_len, req_burst, req_strobe, req_data,
    input  resp_ready, resp_last, resp_data
  );

  modport slave (
    input  req_valid, req_is_write, req_addr, req_len, req_burst, req_strobe, req_data,
    output resp_ready, resp_last, resp_data
  );
endinterface

// File: rtl/cbus_burst_addr_gen.sv
// Burst word-index generator: latches start/len/burst on load, steps FIXED/INCR/WRAP on advance.
module cbus_burst_addr_gen
  import cbus_ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_beat
);

  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  count;
  burst_t                burst_q;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next;
  logic [LEN_WIDTH:0]    blk;
  logic                  wrap_ok;

  assign incr      = addr + 1'b1;
  assign wrap_mask = ADDR_WIDTH'(len_q);
  assign blk       = {1'b0, len_q} + 1'b1;
  // A wrap block must be a power of two; otherwise WRAP degrades to INCR
  assign wrap_ok   = (blk & {1'b0, len_q}) == '0;
  assign last_beat = (count == len_q);

  always_comb begin
    next = incr;
    unique case (burst_q)
      BURST_FIXED: next = addr;
      BURST_WRAP:  if (wrap_ok) next = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     next = incr;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      count   <= '0;
      len_q   <= '0;
      burst_q <= BURST_INCR;
    end else if (load) begin
      addr    <= start;
      count   <= '0;
      len_q   <= len;
      burst_q <= burst;
    end else if (advance) begin
      addr    <= next;
      count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cbus_ram_responder.sv
// cbus burst responder driving a byte-strobed single-port RAM with 0..2 cycles of read latency.
module cbus_ram_responder
  import cbus_ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_LEN      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  cbus_ram_responder_if.slave     bus,
  output logic                    ram_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH/8-1:0] ram_strobe,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int unsigned OFS = byte_ofs(DATA_WIDTH);
  localparam int unsigned LW  = $clog2(MAX_LEN);

  state_t                state, state_next;
  logic                  issuing_q;
  logic                  load, advance, last_beat;
  logic [ADDR_WIDTH-1:0] start_idx;
  resp_tok_t             tok_in, tok_tap;
  logic                  unused_addr_bits;

  assign start_idx        = bus.req_addr[OFS+ADDR_WIDTH-1:OFS];
  assign unused_addr_bits = ^{bus.req_addr[63:OFS+ADDR_WIDTH], bus.req_addr[OFS-1:0]};

  cbus_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LW)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .advance   (advance),
    .start     (start_idx),
    .len       (bus.req_len),
    .burst     (burst_t'(bus.req_burst)),
    .addr      (ram_addr),
    .last_beat (last_beat)
  );

  assign tok_in = '{ready: (state == S_READ) && issuing_q, last: last_beat};

  // Tap L of the token pipe lines up with the RAM data for the beat issued L cycles earlier
  if (READ_LATENCY == 0) begin : g_no_pipe
    assign tok_tap = tok_in;
  end else begin : g_pipe
    resp_tok_t pipe [READ_LATENCY];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= tok_in;
        for (int unsigned i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign tok_tap = pipe[READ_LATENCY-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      issuing_q <= 1'b0;
    end else begin
      state <= state_next;
      if (load)                             issuing_q <= !bus.req_is_write;
      else if (tok_in.ready && tok_in.last) issuing_q <= 1'b0;
    end
  end

  always_comb begin
    state_next     = state;
    load           = 1'b0;
    advance        = 1'b0;
    ram_en         = 1'b0;
    ram_strobe     = '0;
    ram_wdata      = '0;
    bus.resp_ready = 1'b0;
    bus.resp_last  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          load       = 1'b1;
          state_next = bus.req_is_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        ram_en         = 1'b1;
        ram_strobe     = bus.req_strobe;
        ram_wdata      = bus.req_data;
        bus.resp_ready = 1'b1;
        bus.resp_last  = last_beat;
        advance        = 1'b1;
        if (last_beat) state_next = S_IDLE;
      end
      S_READ: begin
        ram_en         = tok_in.ready;
        advance        = tok_in.ready;
        bus.resp_ready = tok_tap.ready;
        bus.resp_last  = tok_tap.ready && tok_tap.last;
        if (tok_tap.ready && tok_tap.last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.resp_data = ((state == S_READ) && tok_tap.ready) ? ram_rdata : '0;

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench: three responders (read latency 0/1/2), each with its own behavioural RAM.
module tb_cbus_ram_responder;
  import cbus_ram_responder_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned NI = 3;
  localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b0;
  always #5 clk = ~clk;

  cbus_ram_responder_if #(.DATA_WIDTH(DW), .MAX_LEN(16)) bus [NI] ();

  logic          ram_en     [NI];
  logic [AW-1:0] ram_addr   [NI];
  logic [SW-1:0] ram_strobe [NI];
  logic [DW-1:0] ram_wdata  [NI];
  logic [DW-1:0] ram_rdata  [NI];
  logic          rdy        [NI];
  logic          lst        [NI];
  logic [DW-1:0] rdat       [NI];
  logic [DW-1:0] mem [NI][1<<AW];
  logic [DW-1:0] rd_p1 [NI];
  logic [DW-1:0] rd_p2 [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cbus_ram_responder #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .READ_LATENCY (g),
      .MAX_LEN      (16)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus[g]),
      .ram_en     (ram_en[g]),
      .ram_addr   (ram_addr[g]),
      .ram_strobe (ram_strobe[g]),
      .ram_wdata  (ram_wdata[g]),
      .ram_rdata  (ram_rdata[g])
    );
    assign rdy[g]  = bus[g].resp_ready;
    assign lst[g]  = bus[g].resp_last;
    assign rdat[g] = bus[g].resp_data;
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (mem_init) begin
        for (int k = 0; k < (1 << AW); k++) mem[i][k] <= PAT | 64'(k);
      end else if (ram_en[i]) begin
        for (int b = 0; b < SW; b++)
          if (ram_strobe[i][b]) mem[i][ram_addr[i]][8*b +: 8] <= ram_wdata[i][8*b +: 8];
      end
      rd_p1[i] <= mem[i][ram_addr[i]];
      rd_p2[i] <= rd_p1[i];
    end
  end

  always_comb begin
    ram_rdata[0] = mem[0][ram_addr[0]];
    ram_rdata[1] = rd_p1[1];
    ram_rdata[2] = rd_p2[2];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NI-1:0] m, input logic v, input logic w, input logic [63:0] a,
                       input logic [3:0] l, input logic [1:0] b, input logic [SW-1:0] s,
                       input logic [DW-1:0] d);
    if (m[0]) begin
      bus[0].req_valid = v; bus[0].req_is_write = w; bus[0].req_addr = a;
      bus[0].req_len = l; bus[0].req_burst = b; bus[0].req_strobe = s; bus[0].req_data = d;
    end
    if (m[1]) begin
      bus[1].req_valid = v; bus[1].req_is_write = w; bus[1].req_addr = a;
      bus[1].req_len = l; bus[1].req_burst = b; bus[1].req_strobe = s; bus[1].req_data = d;
    end
    if (m[2]) begin
      bus[2].req_valid = v; bus[2].req_is_write = w; bus[2].req_addr = a;
      bus[2].req_len = l; bus[2].req_burst = b; bus[2].req_strobe = s; bus[2].req_data = d;
    end
  endtask

  logic [DW-1:0] wbuf [16];
  logic [SW-1:0] sbuf [16];
  logic [DW-1:0] cap_data [16];
  logic          cap_last [16];
  int            cap_cyc  [16];
  int            cap_n;
  int            cap_en;

  // Cycle 1 is the accept (bubble) cycle; beats are captured at negedge.
  task automatic burst(input int inst, input logic [NI-1:0] m, input logic w, input logic [63:0] a,
                       input logic [3:0] l, input logic [1:0] b);
    int cyc = 0;
    int beat = 0;
    cap_en = 0;
    @(posedge clk); #1;
    drive(m, 1'b1, w, a, l, b, sbuf[0], wbuf[0]);
    while (beat <= int'(l) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check($sformatf("bubble_i%0d", inst), 64'({ram_en[inst], rdy[inst]}), 64'd0);
      if (ram_en[inst]) cap_en++;
      if (rdy[inst]) begin
        cap_data[beat] = rdat[inst];
        cap_last[beat] = lst[inst];
        cap_cyc[beat]  = cyc;
        beat++;
      end
      @(posedge clk); #1;
      if (beat <= int'(l)) drive(m, 1'b1, w, a, l, b, sbuf[beat], wbuf[beat]);
    end
    drive(m, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    cap_n = beat;
    check($sformatf("beats_i%0d", inst), 64'(cap_n), 64'(l) + 64'd1);
    check($sformatf("en_cycles_i%0d", inst), 64'(cap_en), 64'(l) + 64'd1);
  endtask

  typedef struct packed {
    logic [1:0]         inst;
    logic [63:0]        addr;
    logic [3:0]         len;
    logic [1:0]         burst;
    logic [3:0]         first;
    logic [3:0][DW-1:0] beats;
  } rvec_t;

  localparam int NV = 9;
  rvec_t tv [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NI-1:0] m;
    int cyc;
    logic got;
    logic [DW-1:0] dv;
    logic lv;

    tv[0] = '{inst: 0, addr: 64'h40, len: 3, burst: 1, first: 2, beats: {64'h44, 64'h33, 64'h22, 64'h11}};
    tv[1] = '{inst: 1, addr: 64'h40, len: 3, burst: 1, first: 3, beats: {64'h44, 64'h33, 64'h22, 64'h11}};
    tv[2] = '{inst: 2, addr: 64'h40, len: 3, burst: 1, first: 4, beats: {64'h44, 64'h33, 64'h22, 64'h11}};
    tv[3] = '{inst: 0, addr: 64'h50, len: 3, burst: 2, first: 2, beats: {64'h22, 64'h11, 64'h44, 64'h33}};
    tv[4] = '{inst: 0, addr: 64'h48, len: 2, burst: 0, first: 2, beats: {64'h0, 64'h22, 64'h22, 64'h22}};
    tv[5] = '{inst: 0, addr: 64'h1FF8, len: 1, burst: 1, first: 2, beats: {64'h0, 64'h0, PAT, PAT | 64'h3FF}};
    tv[6] = '{inst: 2, addr: 64'h50, len: 3, burst: 2, first: 4, beats: {64'h22, 64'h11, 64'h44, 64'h33}};
    tv[7] = '{inst: 0, addr: 64'hFFFF_0000_0000_0040, len: 1, burst: 3, first: 2, beats: {64'h0, 64'h0, 64'h22, 64'h11}};
    tv[8] = '{inst: 0, addr: 64'h50, len: 2, burst: 2, first: 2, beats: {64'h0, PAT | 64'hC, 64'h44, 64'h33}};

    drive(3'b111, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    reset = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(rdy[0]), 64'd0);
    check("rst_last", 64'(lst[0]), 64'd0);
    check("rst_ram_en", 64'(ram_en[0]), 64'd0);
    check("rst_strobe", 64'(ram_strobe[0]), 64'd0);
    check("rst_ram_addr", 64'(ram_addr[0]), 64'd0);
    check("rst_resp_data", rdat[0], 64'd0);
    reset = 1'b0;

    // INCR write len=3 @0x40 on all instances
    for (int k = 0; k < 4; k++) begin
      wbuf[k] = 64'h11 * 64'(k + 1);
      sbuf[k] = '1;
    end
    burst(0, 3'b111, 1'b1, 64'h40, 4'd3, 2'd1);
    for (int k = 0; k < cap_n; k++) begin
      check($sformatf("wr_cyc%0d", k), 64'(cap_cyc[k]), 64'(2 + k));
      check($sformatf("wr_last%0d", k), 64'(cap_last[k]), 64'(k == 3));
    end
    for (int k = 0; k < 4; k++) check($sformatf("wr_mem%0d", 8 + k), mem[0][8 + k], 64'h11 * 64'(k + 1));
    check("wr_mem11_i2", mem[2][11], 64'h44);
    check("wr_mem12_untouched", mem[0][12], PAT | 64'hC);

    for (int t = 0; t < NV; t++) begin
      m = 3'b001 << tv[t].inst;
      burst(int'(tv[t].inst), m, 1'b0, tv[t].addr, tv[t].len, tv[t].burst);
      for (int k = 0; k <= int'(tv[t].len) && k < cap_n; k++) begin
        check($sformatf("v%0d_data%0d", t, k), cap_data[k], tv[t].beats[k]);
        check($sformatf("v%0d_cyc%0d", t, k), 64'(cap_cyc[k]), 64'(tv[t].first) + 64'(k));
        check($sformatf("v%0d_last%0d", t, k), 64'(cap_last[k]), 64'(k == int'(tv[t].len)));
      end
    end

    // Byte-strobe merge on word 20
    wbuf[0] = 64'h1111_2222_3333_4444; sbuf[0] = 8'hFF;
    burst(0, 3'b111, 1'b1, 64'hA0, 4'd0, 2'd1);
    wbuf[0] = 64'hAAAA_AAAA_BBBB_BBBB; sbuf[0] = 8'h0F;
    burst(0, 3'b111, 1'b1, 64'hA0, 4'd0, 2'd1);
    burst(0, 3'b001, 1'b0, 64'hA0, 4'd0, 2'd1);
    check("strobe_readback", cap_data[0], 64'h1111_2222_BBBB_BBBB);
    check("strobe_mem_i1", mem[1][20], 64'h1111_2222_BBBB_BBBB);

    // Reset in the third beat of an 8-beat write
    for (int k = 0; k < 8; k++) begin
      wbuf[k] = 64'hC0DE_0000_0000_0000 | 64'(k + 1);
      sbuf[k] = '1;
    end
    @(posedge clk); #1;
    drive(3'b111, 1'b1, 1'b1, 64'h0, 4'd7, 2'd1, sbuf[0], wbuf[0]);
    cyc = 0;
    got = 1'b0;
    begin
      int beat = 0;
      while (beat < 2 && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (rdy[0]) beat++;
        @(posedge clk); #1;
        drive(3'b111, 1'b1, 1'b1, 64'h0, 4'd7, 2'd1, sbuf[beat], wbuf[beat]);
      end
      check("rst_mid_beats_seen", 64'(beat), 64'd2);
    end
    check("rst_mid_ready_before", 64'(rdy[0]), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_ready", 64'(rdy[0]), 64'd0);
    check("rst_mid_ram_en", 64'(ram_en[0]), 64'd0);
    drive(3'b111, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++)
      check($sformatf("rst_mid_mem%0d", k), mem[0][k], (k < 2) ? wbuf[k] : (PAT | 64'(k)));
    burst(0, 3'b001, 1'b0, 64'h0, 4'd1, 2'd1);
    check("post_rst_d0", cap_data[0], wbuf[0]);
    check("post_rst_d1", cap_data[1], wbuf[1]);
    check("post_rst_cyc0", 64'(cap_cyc[0]), 64'd2);
    burst(2, 3'b100, 1'b0, 64'h10, 4'd0, 2'd0);
    check("post_rst_l2_data", cap_data[0], PAT | 64'h2);
    check("post_rst_l2_cyc", 64'(cap_cyc[0]), 64'd4);

    // Back-to-back: read request presented in the cycle after the write's last beat
    wbuf[0] = 64'h5A5A_5A5A_0123_4567;
    @(posedge clk); #1;
    drive(3'b001, 1'b1, 1'b1, 64'hF0, 4'd0, 2'd1, 8'hFF, wbuf[0]);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rdy[0]) got = 1'b1;
      @(posedge clk); #1;
    end
    check("b2b_wr_cyc", 64'(cyc), 64'd2);
    drive(3'b001, 1'b1, 1'b0, 64'hF0, 4'd0, 2'd1, '0, '0);
    cyc = 0;
    got = 1'b0;
    dv = '0;
    lv = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rdy[0]) begin
        got = 1'b1;
        dv = rdat[0];
        lv = lst[0];
      end
      @(posedge clk); #1;
    end
    drive(3'b001, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    check("b2b_rd_cyc", 64'(cyc), 64'd2);
    check("b2b_rd_data", dv, 64'h5A5A_5A5A_0123_4567);
    check("b2b_rd_last", 64'(lv), 64'd1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
